// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared constants and elaboration-time helpers for the FIFO read-side stream
// adapter (fifo_rd_stream) and its output buffer (stream_out_buf).
// No ports; imported with `import fifo_rd_stream_pkg::*;`.
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Bits needed to index n entries, never less than 1 so a 1-entry
    // structure still gets a real pointer.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic bit rd_lat_legal(input int rd_latency);
        return (rd_latency >= RD_LAT_MIN) && (rd_latency <= RD_LAT_MAX);
    endfunction

    // Every in-flight read needs a reserved buffer slot plus at least one
    // slot for the word being presented to the sink.
    function automatic bit buf_depth_legal(input int rd_latency, input int buf_depth);
        return buf_depth >= (rd_latency + 1);
    endfunction

endpackage

// File: rtl/stream_out_buf.sv
// -----------------------------------------------------------------------------
// stream_out_buf
// Circular output buffer with valid/ready pop, used by fifo_rd_stream to hold
// words returned by the FIFO until the sink accepts them.
//
// Ports
//   clk_i      in   clock, rising edge
//   arst_n_i   in   asynchronous active-low reset (clears level/pointers)
//   wr_en_i    in   write wr_data_i at the write pointer this cycle
//   wr_data_i  in   DWIDTH  word returned from the FIFO
//   tready_i   in   sink ready
//   tdata_o    out  DWIDTH  word at the read pointer (0 when empty)
//   tvalid_o   out  buffer non-empty
//   level_o    out  words currently held
// -----------------------------------------------------------------------------
module stream_out_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter  int DWIDTH = 16,
    parameter  int DEPTH  = 4,
    localparam int LW     = $clog2(DEPTH + 1),
    localparam int PW     = clog2_min1(DEPTH)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              wr_en_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              tready_i,
    output logic [DWIDTH-1:0] tdata_o,
    output logic              tvalid_o,
    output logic [LW-1:0]     level_o
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_pop;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign tvalid_o = (r_level != '0);
    assign w_pop    = tvalid_o && tready_i;
    // Storage is not reset; masking keeps tdata_o at 0 whenever nothing is valid.
    assign tdata_o  = tvalid_o ? r_mem[r_rd_ptr] : '0;
    assign level_o  = r_level;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (wr_en_i) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (wr_en_i && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!wr_en_i && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!arst_n_i)
        wr_en_i |-> (r_level != LW'(DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Reads a single-clock FIFO and presents its words as a valid/ready stream.
// The FIFO's fixed read latency is hidden by issuing reads against credits
// (free output-buffer slots not already claimed by in-flight reads).
//
// Ports
//   clk_i         in   clock, rising edge
//   arst_n_i      in   asynchronous active-low reset
//   fifo_empty_i  in   FIFO empty flag (registered inside the FIFO)
//   fifo_q_i      in   DWIDTH  FIFO read data, valid RD_LATENCY cycles after rdreq
//   fifo_rdreq_o  out  FIFO read request
//   tdata_o       out  DWIDTH  stream data
//   tvalid_o      out  stream valid
//   tready_i      in   sink ready
//   level_o       out  words held in the output buffer
//   inflight_o    out  reads issued whose data has not yet been captured
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter  int DWIDTH     = 16,
    parameter  int RD_LATENCY = 2,
    parameter  int BUF_DEPTH  = 4,
    localparam int LW         = $clog2(BUF_DEPTH + 1),
    localparam int IW         = $clog2(RD_LATENCY + 1)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] tdata_o,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic [LW-1:0]     level_o,
    output logic [IW-1:0]     inflight_o
);

    localparam int SW = LW + 1;

    generate
        if (!rd_lat_legal(RD_LATENCY)) begin : g_bad_latency
            $error("fifo_rd_stream: RD_LATENCY must be in 1..4");
        end
        if (!buf_depth_legal(RD_LATENCY, BUF_DEPTH)) begin : g_bad_depth
            $error("fifo_rd_stream: BUF_DEPTH must be >= RD_LATENCY+1");
        end
    endgenerate

    logic [RD_LATENCY-1:0] r_lat_pipe;
    logic [IW-1:0]         w_inflight;
    logic [LW-1:0]         w_level;
    logic [SW-1:0]         w_credit_used;
    logic                  w_rdreq;
    logic                  w_buf_wr;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + IW'(r_lat_pipe[i]);
        end
    end

    // Registered level only: a same-cycle pop is not credited, which keeps
    // tready_i out of the rdreq timing path.
    assign w_credit_used = SW'(w_level) + SW'(w_inflight);

    // The reset term holds rdreq low while reset is asserted even though a
    // preloaded FIFO may report non-empty.
    assign w_rdreq = arst_n_i && !fifo_empty_i && (w_credit_used < SW'(BUF_DEPTH));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_lat_pipe <= '0;
        end else begin
            r_lat_pipe[0] <= w_rdreq;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_lat_pipe[i] <= r_lat_pipe[i-1];
            end
        end
    end

    // Last stage set means fifo_q_i carries the requested word this cycle.
    assign w_buf_wr = r_lat_pipe[RD_LATENCY-1];

    stream_out_buf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .wr_en_i   (w_buf_wr),
        .wr_data_i (fifo_q_i),
        .tready_i  (tready_i),
        .tdata_o   (tdata_o),
        .tvalid_o  (tvalid_o),
        .level_o   (w_level)
    );

    assign fifo_rdreq_o = w_rdreq;
    assign level_o      = w_level;
    assign inflight_o   = w_inflight;

    a_no_empty_read : assert property (@(posedge clk_i) disable iff (!arst_n_i)
        !(fifo_rdreq_o && fifo_empty_i));

endmodule
